read_inc: RTL

//  Read-side pointer and status controller of the async FIFO, the counterpart of the write-pointer/full block.

---
 rtl/read_inc_if.sv | 24 ++
 rtl/read_inc.sv | 84 ++++++++
 2 files changed

// File: rtl/read_inc_if.sv
// rtl/read_inc_if.sv - read-side FIFO pointer/status bus between the read domain and its user
interface read_inc_if #(
  parameter int ADDRSIZE = 4
);
  logic                signal_read;
  logic [ADDRSIZE:0]   graycode_wptr;
  logic                empty;
  logic                almost_empty;
  logic [ADDRSIZE-1:0] read_address;
  logic [ADDRSIZE:0]   graycode_rptr;
  logic                rd_valid;
  logic [ADDRSIZE:0]   rd_count;
  logic                underflow;

  modport master (
    output signal_read, graycode_wptr,
    input  empty, almost_empty, read_address, graycode_rptr, rd_valid, rd_count, underflow
  );

  modport slave (
    input  signal_read, graycode_wptr,
    output empty, almost_empty, read_address, graycode_rptr, rd_valid, rd_count, underflow
  );
endinterface

// File: rtl/read_inc.sv
// rtl/read_inc.sv - async FIFO read pointer, write-pointer synchronizer and empty/occupancy status
module read_inc #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AEMPTY_LVL  = 2
) (
  input  logic       clk,
  input  logic       rst,
  read_inc_if.slave  bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_LVL);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PW-1:0] wq_q, wq_d;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          valid_q, valid_d;
  logic          under_q, under_d;
  logic          accept;
  logic [PW-1:0] wq_s;

  assign wq_s = wq_q[SYNC_STAGES-1];

  always_comb begin
    wq_d = wq_q;
    wq_d[0] = bus.graycode_wptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      wq_d[i] = wq_q[i-1];
    end

    accept  = bus.signal_read & ~empty_q;
    rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, accept};
    rgray_d = (rbin_d >> 1) ^ rbin_d;

    // Status uses the post-read pointer so a same-cycle read and pointer arrival resolve together
    empty_d  = (rgray_d == wq_s);
    cnt_d    = gray2bin(wq_s) - rbin_d;
    aempty_d = (cnt_d <= AE_LVL);
    valid_d  = accept;
    under_d  = under_q | (bus.signal_read & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wq_q     <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      wq_q     <= wq_d;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      valid_q  <= valid_d;
      under_q  <= under_d;
    end
  end

  assign bus.empty         = empty_q;
  assign bus.almost_empty  = aempty_q;
  assign bus.read_address  = rbin_q[ADDRSIZE-1:0];
  assign bus.graycode_rptr = rgray_q;
  assign bus.rd_valid      = valid_q;
  assign bus.rd_count      = cnt_q;
  assign bus.underflow     = under_q;
endmodule
